// File: rtl/ibex_hpm_counter_bank_pkg.sv
// Shared definitions for the machine counter/timer bank: CSR address
// offsets, the counter limit, the event index enum and a helper that
// derives the writable bits of mcountinhibit from the counter count.
package ibex_hpm_counter_bank_pkg;

  localparam int unsigned MHPM_MAX_COUNTERS = 29;

  localparam logic [11:0] CSR_OFF_MHPMCOUNTER  = 12'hB00;
  localparam logic [11:0] CSR_OFF_MHPMCOUNTERH = 12'hB80;
  localparam logic [11:0] CSR_OFF_MHPMEVENT    = 12'h320;
  localparam logic [11:0] CSR_MCOUNTINHIBIT    = 12'h320;

  // Counter indices within a CSR group (low 5 address bits)
  localparam logic [4:0] CNT_IDX_MCYCLE   = 5'd0;
  localparam logic [4:0] CNT_IDX_TIME     = 5'd1;
  localparam logic [4:0] CNT_IDX_MINSTRET = 5'd2;
  localparam logic [4:0] CNT_IDX_HPM_BASE = 5'd3;

  typedef enum logic [4:0] {
    HPM_EV_CYCLE        = 5'd0,
    HPM_EV_INSTR_RET    = 5'd1,
    HPM_EV_LOAD         = 5'd2,
    HPM_EV_STORE        = 5'd3,
    HPM_EV_JUMP         = 5'd4,
    HPM_EV_BRANCH       = 5'd5,
    HPM_EV_BRANCH_TAKEN = 5'd6,
    HPM_EV_COMP_INSTR   = 5'd7,
    HPM_EV_MEM_WAIT     = 5'd8,
    HPM_EV_IFETCH_WAIT  = 5'd9,
    HPM_EV_MUL_WAIT     = 5'd10,
    HPM_EV_DIV_WAIT     = 5'd11
  } ibex_hpm_event_e;

  // mcountinhibit: bit 0 (mcycle), bit 2 (minstret) and one bit per
  // implemented mhpmcounter are writable; everything else is hardwired 0.
  function automatic logic [31:0] inhibit_mask(input int unsigned num_counters);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int unsigned i = 0; i < num_counters; i++) begin
      m[3+i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ibex_hpm_counter_bank_counter.sv
// ibex_counter: one CSR-writable free-running counter.
//   clk_i, rst_i     clock, asynchronous active-high reset
//   counter_inc_i    add one at the next edge (ignored when written)
//   we_lo_i/we_hi_i  replace bits [31:0] / [W-1:32] with wdata_i
//   wdata_i          write data
//   val_o            counter value zero-extended to 64 bits
//   overflow_o       registered pulse, high the cycle after an all-ones wrap
module ibex_counter #(
  parameter int unsigned CounterWidth = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        counter_inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] val_o,
  output logic        overflow_o
);

  logic [CounterWidth-1:0] count_q, count_d;
  logic [63:0]             wr_val;
  logic                    we;
  logic                    ovf_d;

  assign we = we_lo_i | we_hi_i;

  always_comb begin
    // Merge the write into a 64-bit view, then truncate: high-half writes
    // to a counter of 32 bits or less simply fall off.
    wr_val = 64'(count_q);
    if (we_lo_i) wr_val[31:0]  = wdata_i;
    if (we_hi_i) wr_val[63:32] = wdata_i;

    if (we)                 count_d = CounterWidth'(wr_val);
    else if (counter_inc_i) count_d = count_q + CounterWidth'(1);
    else                    count_d = count_q;

    ovf_d = counter_inc_i & ~we & (&count_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= '0;
      overflow_o <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_o <= ovf_d;
    end
  end

  assign val_o = 64'(count_q);

endmodule

// File: rtl/ibex_hpm_counter_bank.sv
// Machine counter/timer bank: mcycle, minstret, NumCounters programmable
// mhpmcounters with mhpmevent masks, and mcountinhibit.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   csr_we_i       CSR write strobe (already privilege/legality gated)
//   csr_addr_i     CSR address
//   csr_wdata_i    final CSR write data
//   csr_rdata_o    combinational read data for csr_addr_i
//   csr_hit_o      csr_addr_i belongs to this bank
//   instret_i      an instruction retired this cycle
//   event_i        per-cycle event strobes
//   overflow_o     per-mhpmcounter wrap pulse
module ibex_hpm_counter_bank
  import ibex_hpm_counter_bank_pkg::*;
#(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   csr_we_i,
  input  logic [11:0]            csr_addr_i,
  input  logic [31:0]            csr_wdata_i,
  output logic [31:0]            csr_rdata_o,
  output logic                   csr_hit_o,
  input  logic                   instret_i,
  input  logic [NumEvents-1:0]   event_i,
  output logic [NumCounters-1:0] overflow_o
);

  if (NumCounters > MHPM_MAX_COUNTERS) begin : g_chk_num_counters
    $error("NumCounters must be <= 29");
  end
  if (CounterWidth < 1 || CounterWidth > 64) begin : g_chk_counter_width
    $error("CounterWidth must be within 1..64");
  end
  if (NumEvents < 1 || NumEvents > 32) begin : g_chk_num_events
    $error("NumEvents must be within 1..32");
  end

  localparam logic [31:0] InhibitMask = inhibit_mask(NumCounters);

  logic [4:0]  idx;
  logic        sel_inhibit, sel_event, sel_cnt_lo, sel_cnt_hi;
  logic [31:0] inhibit_q;
  logic [63:0] mcycle_val, minstret_val;
  logic [63:0] hpm_val   [NumCounters];
  logic [31:0] event_val [NumCounters];
  logic        unused_ovf_mcycle, unused_ovf_minstret;

  // Address decode: 0x320 is mcountinhibit, 0x321/0x322 do not exist,
  // 0x323..0x33F are mhpmevents; index 1 (time) is not owned here.
  assign idx         = csr_addr_i[4:0];
  assign sel_inhibit = (csr_addr_i == CSR_MCOUNTINHIBIT);
  assign sel_event   = (csr_addr_i[11:5] == CSR_OFF_MHPMEVENT[11:5]) &&
                       (idx >= CNT_IDX_HPM_BASE);
  assign sel_cnt_lo  = (csr_addr_i[11:5] == CSR_OFF_MHPMCOUNTER[11:5]) &&
                       (idx != CNT_IDX_TIME);
  assign sel_cnt_hi  = (csr_addr_i[11:5] == CSR_OFF_MHPMCOUNTERH[11:5]) &&
                       (idx != CNT_IDX_TIME);
  assign csr_hit_o   = sel_inhibit | sel_event | sel_cnt_lo | sel_cnt_hi;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inhibit_q <= '0;
    end else if (csr_we_i && sel_inhibit) begin
      inhibit_q <= csr_wdata_i & InhibitMask;
    end
  end

  ibex_counter #(
    .CounterWidth(64)
  ) u_mcycle (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .counter_inc_i(~inhibit_q[0]),
    .we_lo_i      (csr_we_i & sel_cnt_lo & (idx == CNT_IDX_MCYCLE)),
    .we_hi_i      (csr_we_i & sel_cnt_hi & (idx == CNT_IDX_MCYCLE)),
    .wdata_i      (csr_wdata_i),
    .val_o        (mcycle_val),
    .overflow_o   (unused_ovf_mcycle)
  );

  ibex_counter #(
    .CounterWidth(64)
  ) u_minstret (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .counter_inc_i(instret_i & ~inhibit_q[2]),
    .we_lo_i      (csr_we_i & sel_cnt_lo & (idx == CNT_IDX_MINSTRET)),
    .we_hi_i      (csr_we_i & sel_cnt_hi & (idx == CNT_IDX_MINSTRET)),
    .wdata_i      (csr_wdata_i),
    .val_o        (minstret_val),
    .overflow_o   (unused_ovf_minstret)
  );

  for (genvar i = 0; i < NumCounters; i++) begin : g_hpm
    localparam logic [4:0] Idx = 5'(3 + i);

    logic [NumEvents-1:0] mask_q;
    logic                 sel;
    logic                 inc;

    assign sel = (idx == Idx);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        mask_q <= '0;
      end else if (csr_we_i && sel_event && sel) begin
        mask_q <= csr_wdata_i[NumEvents-1:0];
      end
    end

    // Any number of selected events in one cycle counts once.
    assign inc          = (|(event_i & mask_q)) & ~inhibit_q[3+i];
    assign event_val[i] = 32'(mask_q);

    ibex_counter #(
      .CounterWidth(CounterWidth)
    ) u_cnt (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .counter_inc_i(inc),
      .we_lo_i      (csr_we_i & sel_cnt_lo & sel),
      .we_hi_i      (csr_we_i & sel_cnt_hi & sel),
      .wdata_i      (csr_wdata_i),
      .val_o        (hpm_val[i]),
      .overflow_o   (overflow_o[i])
    );
  end

  logic [63:0] cnt_sel;
  logic [31:0] ev_sel;

  always_comb begin
    cnt_sel = '0;
    ev_sel  = '0;
    if (idx == CNT_IDX_MCYCLE)   cnt_sel = mcycle_val;
    if (idx == CNT_IDX_MINSTRET) cnt_sel = minstret_val;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      if (idx == 5'(3 + i)) begin
        cnt_sel = hpm_val[i];
        ev_sel  = event_val[i];
      end
    end

    csr_rdata_o = '0;
    if (sel_inhibit)     csr_rdata_o = inhibit_q;
    else if (sel_event)  csr_rdata_o = ev_sel;
    else if (sel_cnt_lo) csr_rdata_o = cnt_sel[31:0];
    else if (sel_cnt_hi) csr_rdata_o = cnt_sel[63:32];
  end

endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
module tb_ibex_hpm_counter_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        instret;
  logic [15:0] event_in;
  logic [7:0]  overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ibex_hpm_counter_bank #(
    .NumCounters (8),
    .CounterWidth(40),
    .NumEvents   (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .csr_we_i   (csr_we),
    .csr_addr_i (csr_addr),
    .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata),
    .csr_hit_o  (csr_hit),
    .instret_i  (instret),
    .event_i    (event_in),
    .overflow_o (overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string name);
    csr_addr = addr;
    #1;
    chk(name, 64'(csr_rdata), 64'(exp));
  endtask

  // Called right after a negedge; returns at the following negedge.
  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    @(posedge clk);
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  typedef struct packed {
    logic [11:0] addr;
    logic        hit;
  } rst_vec_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } wr_vec_t;

  rst_vec_t rtab[11];
  wr_vec_t  wtab[13];

  initial begin
    rtab[0]  = '{12'h320, 1'b1};
    rtab[1]  = '{12'h321, 1'b0};
    rtab[2]  = '{12'h323, 1'b1};
    rtab[3]  = '{12'h33F, 1'b1};
    rtab[4]  = '{12'hB00, 1'b1};
    rtab[5]  = '{12'hB01, 1'b0};
    rtab[6]  = '{12'hB82, 1'b1};
    rtab[7]  = '{12'hB9F, 1'b1};
    rtab[8]  = '{12'h000, 1'b0};
    rtab[9]  = '{12'hB20, 1'b0};
    rtab[10] = '{12'h340, 1'b0};

    wtab[0]  = '{12'h320, 32'hFFFF_FFFF, 32'h0000_07FD};
    wtab[1]  = '{12'h323, 32'hFFFF_FFFF, 32'h0000_FFFF};
    wtab[2]  = '{12'h32A, 32'hABCD_1234, 32'h0000_1234};
    wtab[3]  = '{12'h32B, 32'hFFFF_FFFF, 32'h0000_0000};
    wtab[4]  = '{12'hB04, 32'h1234_5678, 32'h1234_5678};
    wtab[5]  = '{12'hB84, 32'hFFFF_FF12, 32'h0000_0012};
    wtab[6]  = '{12'hB0A, 32'hCAFE_F00D, 32'hCAFE_F00D};
    wtab[7]  = '{12'hB0B, 32'hFFFF_FFFF, 32'h0000_0000};
    wtab[8]  = '{12'hB8B, 32'hFFFF_FFFF, 32'h0000_0000};
    wtab[9]  = '{12'hB80, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    wtab[10] = '{12'h323, 32'h0000_0000, 32'h0000_0000};
    wtab[11] = '{12'hB84, 32'h0000_0000, 32'h0000_0000};
    wtab[12] = '{12'h320, 32'h0000_0000, 32'h0000_0000};

    rst       = 1'b1;
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    instret   = 1'b0;
    event_in  = '0;

    // Reset state and address decode, reset held
    #2;
    chk("rst_overflow", 64'(overflow), 64'h0);
    for (int i = 0; i < 11; i++) begin
      rd(rtab[i].addr, 32'h0, $sformatf("rst_rdata_%0d", i));
      chk($sformatf("rst_hit_%0d", i), 64'(csr_hit), 64'(rtab[i].hit));
    end

    // 10 free-running cycles, instret on 4 of them
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      instret = (i % 3 == 0);
      @(negedge clk);
    end
    instret = 1'b0;
    rd(12'hB00, 32'd10, "mcycle_10");
    rd(12'hB80, 32'd0,  "mcycleh_10");
    rd(12'hB02, 32'd4,  "minstret_4");
    rd(12'hB82, 32'd0,  "minstreth_4");

    // Carry from low into high half of mcycle
    wr(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB80, 32'd0,          "mcycleh_pre_carry");
    rd(12'hB00, 32'hFFFF_FFFF,  "mcycle_written");
    @(negedge clk);
    rd(12'hB80, 32'd1, "mcycleh_carry");
    rd(12'hB00, 32'd0, "mcycle_carry_lo");

    // Write/readback table; first row freezes all counters
    for (int i = 0; i < 13; i++) begin
      wr(wtab[i].addr, wtab[i].wdata);
      rd(wtab[i].addr, wtab[i].exp, $sformatf("wtab_%0d", i));
    end

    // mhpmcounter3 wrap with overflow pulse
    wr(12'h323, 32'h0000_0001);
    rd(12'h323, 32'h0000_0001, "mhpmevent3_one");
    wr(12'hB83, 32'h0000_00FF);
    wr(12'hB03, 32'hFFFF_FFFF);
    chk("ovf_after_write", 64'(overflow), 64'h0);
    rd(12'hB03, 32'hFFFF_FFFF, "hpm3_allones_lo");
    rd(12'hB83, 32'h0000_00FF, "hpm3_allones_hi");
    event_in = 16'h0001;
    @(negedge clk);
    event_in = 16'h0000;
    #1;
    chk("ovf_pulse", 64'(overflow), 64'h01);
    rd(12'hB03, 32'h0, "hpm3_wrapped_lo");
    rd(12'hB83, 32'h0, "hpm3_wrapped_hi");
    @(negedge clk);
    #1;
    chk("ovf_cleared", 64'(overflow), 64'h00);

    // Multiple selected events count once; unselected event counts zero
    @(negedge clk);
    wr(12'hB84, 32'h0);
    wr(12'hB04, 32'h0);
    wr(12'h324, 32'h0000_0006);
    rd(12'h324, 32'h0000_0006, "mhpmevent4");
    event_in = 16'h0006;
    @(negedge clk);
    event_in = 16'h0000;
    rd(12'hB04, 32'd1, "hpm4_two_events");
    event_in = 16'h0008;
    @(negedge clk);
    event_in = 16'h0000;
    rd(12'hB04, 32'd1, "hpm4_unselected");

    // Inhibit everything: masked readback and frozen counters
    @(negedge clk);
    wr(12'hB00, 32'd100);
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320, 32'h0000_07FD, "inhibit_mask");
    event_in = 16'hFFFF;
    instret  = 1'b1;
    repeat (5) @(negedge clk);
    event_in = 16'h0000;
    instret  = 1'b0;
    rd(12'hB00, 32'd101, "mcycle_frozen");
    rd(12'hB02, 32'd4,   "minstret_frozen");
    rd(12'hB04, 32'd1,   "hpm4_frozen");
    rd(12'hB03, 32'd0,   "hpm3_frozen");

    // Write beats increment; old value visible during the write cycle
    @(negedge clk);
    event_in = 16'h0001;
    wr(12'h320, 32'h0);
    csr_we    = 1'b1;
    csr_addr  = 12'hB03;
    csr_wdata = 32'd5;
    #1;
    chk("hpm3_no_bypass", 64'(csr_rdata), 64'd0);
    @(posedge clk);
    @(negedge clk);
    csr_we = 1'b0;
    rd(12'hB03, 32'd5, "hpm3_write_wins");
    @(negedge clk);
    rd(12'hB03, 32'd6, "hpm3_after_write");

    // Asynchronous reset mid-run
    #2;
    rst = 1'b1;
    #1;
    rd(12'hB00, 32'd0, "rst_mid_mcycle");
    rd(12'hB03, 32'd0, "rst_mid_hpm3");
    rd(12'h320, 32'd0, "rst_mid_inhibit");
    rd(12'h323, 32'd0, "rst_mid_event3");
    chk("rst_mid_overflow", 64'(overflow), 64'h0);
    event_in = 16'h0000;
    rst      = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
